// File: rtl/score_ram_arbiter_pkg.sv
// Shared constants for the score RAM arbiter: default geometry and grant-side encoding.
package score_ram_arbiter_pkg;

  localparam int unsigned DEF_AW     = 16;
  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned DEF_RD_LAT = 2;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

endpackage

// File: rtl/score_ram_arbiter_rd_pipe.sv
// Read-valid delay line: one bit per accepted read, shifted once per cycle, cleared by reset.
module score_rd_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sh_q;
  logic [DEPTH-1:0] sh_d;

  always_comb begin
    sh_d = {sh_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (!rst) sh_q <= '0;
    else      sh_q <= sh_d;
  end

  assign dout = sh_q[DEPTH-1];

endmodule

// File: rtl/score_ram_arbiter.sv
// Round-robin arbiter sharing one external single-port score RAM between
// the game-update writer and the scoreboard-scan reader.
module score_ram_arbiter
  import score_ram_arbiter_pkg::*;
#(
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_rvalid,
  output logic [DW-1:0] rd_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_rdata
);

  gnt_e          ptr_q, ptr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_wren_q, ram_wren_d;
  logic          rd_rvalid_q, rd_rvalid_d;
  logic [DW-1:0] rd_rdata_q, rd_rdata_d;
  logic          rd_data_here;

  // Pipe output lines up with the cycle ram_rdata holds the read's data.
  score_rd_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_ready),
    .dout (rd_data_here)
  );

  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    ptr_d    = ptr_q;
    if (rst) begin
      if (wr_valid && rd_valid) begin
        // Pointer only advances on contested cycles.
        if (ptr_q == GNT_WR) wr_ready = 1'b1;
        else                 rd_ready = 1'b1;
        ptr_d = (ptr_q == GNT_WR) ? GNT_RD : GNT_WR;
      end else begin
        wr_ready = wr_valid;
        rd_ready = rd_valid;
      end
    end
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wren_d  = 1'b0;
    if (wr_ready) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      ram_wren_d  = 1'b1;
    end else if (rd_ready) begin
      ram_addr_d  = rd_addr;
    end
    rd_rvalid_d = rd_data_here;
    rd_rdata_d  = rd_data_here ? ram_rdata : rd_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= GNT_WR;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
      rd_rvalid_q <= 1'b0;
      rd_rdata_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wren_q  <= ram_wren_d;
      rd_rvalid_q <= rd_rvalid_d;
      rd_rdata_q  <= rd_rdata_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wren  = ram_wren_q;
  assign rd_rvalid = rd_rvalid_q;
  assign rd_rdata  = rd_rdata_q;

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Directed bench for score_ram_arbiter with a 2-cycle-latency single-port RAM model.
module tb_score_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] ram_s1, ram_s2;
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always #5 clk = ~clk;

  score_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata)
  );

  // External RAM: data appears RD_LAT=2 cycles after the address.
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_s1 <= mem[ram_addr];
    ram_s2 <= ram_s1;
  end
  assign ram_rdata = ram_s2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b expected 0", rd_ready); end
    @(negedge clk);
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren: got %b expected 0", ram_wren); end
    checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0000", ram_addr); end
    checks++; if (ram_wdata !== 16'h0000) begin errors++; $display("FAIL reset_ram_wdata: got %h expected 0000", ram_wdata); end
    checks++; if (rd_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rd_rvalid: got %b expected 0", rd_rvalid); end
    checks++; if (rd_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rd_rdata: got %h expected 0000", rd_rdata); end
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b1; wr_addr = 16'h0042; wr_data = 16'h0042; rd_valid = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL first_cycle_accept: got %b expected 1", wr_ready); end
    idle(6);
  endtask

  task automatic test_single_write();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 16'h0005; wr_data = 16'h00AA;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL sw_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL sw_rd_ready: got %b expected 0", rd_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL sw_ram_wren: got %b expected 1", ram_wren); end
    checks++; if (ram_addr !== 16'h0005) begin errors++; $display("FAIL sw_ram_addr: got %h expected 0005", ram_addr); end
    checks++; if (ram_wdata !== 16'h00AA) begin errors++; $display("FAIL sw_ram_wdata: got %h expected 00aa", ram_wdata); end
    @(negedge clk);
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL sw_wren_one_cycle: got %b expected 0", ram_wren); end
    checks++; if (ram_addr !== 16'h0005) begin errors++; $display("FAIL sw_addr_hold: got %h expected 0005", ram_addr); end
    checks++; if (ram_wdata !== 16'h00AA) begin errors++; $display("FAIL sw_wdata_hold: got %h expected 00aa", ram_wdata); end
    idle(2);
  endtask

  task automatic test_read_latency();
    logic exp_v;
    preload(16'h0003, 16'h1234);
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 16'h0003;
    #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rl_rd_ready: got %b expected 1", rd_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rd_valid = 1'b0;
      exp_v = (k == 4);
      checks++; if (rd_rvalid !== exp_v) begin errors++; $display("FAIL rl_rvalid_c%0d: got %b expected %b", k, rd_rvalid, exp_v); end
      if (k == 4) begin
        checks++; if (rd_rdata !== 16'h1234) begin errors++; $display("FAIL rl_rdata: got %h expected 1234", rd_rdata); end
      end
    end
  endtask

  task automatic test_addr_extremes();
    logic exp_v;
    preload(16'h0000, 16'h5A5A);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      exp_v = (k == 5) || (k == 6);
      checks++; if (rd_rvalid !== exp_v) begin errors++; $display("FAIL ext_rvalid_c%0d: got %b expected %b", k, rd_rvalid, exp_v); end
      if (k == 5) begin
        checks++; if (rd_rdata !== 16'hFFFF) begin errors++; $display("FAIL ext_rdata_ffff: got %h expected ffff", rd_rdata); end
      end
      if (k == 6) begin
        checks++; if (rd_rdata !== 16'h5A5A) begin errors++; $display("FAIL ext_rdata_0000: got %h expected 5a5a", rd_rdata); end
      end
      if (k == 1) begin
        checks++; if (ram_addr !== 16'hFFFF || ram_wren !== 1'b1) begin errors++; $display("FAIL ext_wr_addr: got %h/%b expected ffff/1", ram_addr, ram_wren); end
      end
      wr_valid = (k == 0); wr_addr = 16'hFFFF; wr_data = 16'hFFFF;
      rd_valid = (k == 1) || (k == 2);
      rd_addr  = (k == 1) ? 16'hFFFF : 16'h0000;
    end
    idle(1);
  endtask

  task automatic test_contention();
    logic exp_w;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = 16'h0010 + 16'(k); wr_data = 16'h0100 + 16'(k);
      rd_valid = 1'b1; rd_addr = 16'h0020 + 16'(k);
      #1;
      exp_w = ((k % 2) == 0);
      checks++; if (wr_ready !== exp_w || rd_ready !== !exp_w) begin errors++; $display("FAIL contention_c%0d: got w%b r%b expected w%b r%b", k, wr_ready, rd_ready, exp_w, !exp_w); end
    end
    @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL uncontested_wr: got %b expected 1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin errors++; $display("FAIL ptr_hold: got w%b r%b expected w1 r0", wr_ready, rd_ready); end
    idle(8);
  endtask

  task automatic test_ordering();
    logic exp_v;
    preload(16'h0007, 16'h0001);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        exp_v = (k == 4) || (k == 6);
        checks++; if (rd_rvalid !== exp_v) begin errors++; $display("FAIL ord_rvalid_c%0d: got %b expected %b", k, rd_rvalid, exp_v); end
        if (k == 4) begin
          checks++; if (rd_rdata !== 16'h0001) begin errors++; $display("FAIL ord_old_data: got %h expected 0001", rd_rdata); end
        end
        if (k == 6) begin
          checks++; if (rd_rdata !== 16'h0009) begin errors++; $display("FAIL ord_new_data: got %h expected 0009", rd_rdata); end
        end
      end
      rd_valid = (k == 0) || (k == 2); rd_addr = 16'h0007;
      wr_valid = (k == 1); wr_addr = 16'h0007; wr_data = 16'h0009;
    end
    idle(1);
  endtask

  task automatic test_reset_mid_burst();
    int pulses;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd_valid = 1'b1; rd_addr = 16'h0002 + 16'(k);
    end
    @(negedge clk);
    rd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got w%b r%b expected w0 r0", wr_ready, rd_ready); end
    checks++; if (ram_addr !== 16'h0000 || ram_wren !== 1'b0 || ram_wdata !== 16'h0000) begin errors++; $display("FAIL mid_reset_ram: got %h/%b/%h expected 0000/0/0000", ram_addr, ram_wren, ram_wdata); end
    checks++; if (rd_rvalid !== 1'b0 || rd_rdata !== 16'h0000) begin errors++; $display("FAIL mid_reset_rd: got %b/%h expected 0/0000", rd_rvalid, rd_rdata); end
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
    pulses = (rd_rvalid === 1'b0) ? 0 : 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_rvalid !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL mid_reset_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_streaming_scan();
    logic          exp_v;
    logic [DW-1:0] exp_d;
    for (int a = 0; a < 256; a++) preload(16'(a), 16'h1000 + 16'(a * 7));
    for (int k = 0; k < 264; k++) begin
      @(negedge clk);
      exp_v = (k >= 4) && (k < 260);
      checks++; if (rd_rvalid !== exp_v) begin errors++; $display("FAIL scan_rvalid_c%0d: got %b expected %b", k, rd_rvalid, exp_v); end
      if (exp_v) begin
        exp_d = 16'h1000 + 16'((k - 4) * 7);
        checks++; if (rd_rdata !== exp_d) begin errors++; $display("FAIL scan_rdata_c%0d: got %h expected %h", k, rd_rdata, exp_d); end
      end
      rd_valid = (k < 256); rd_addr = 16'(k); wr_valid = 1'b0;
      #1;
      if (k < 256) begin
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL scan_rd_ready_c%0d: got %b expected 1", k, rd_ready); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_latency();
    test_addr_extremes();
    test_contention();
    test_ordering();
    test_reset_mid_burst();
    test_streaming_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
